// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants used by the forwarding/hazard control block.
package cpu_pkg;

    // Operand select value meaning "take the operand from the register file".
    localparam int FW_SEL_RF = 0;

    // Architectural zero register; it never carries a forwarded value.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the multicycle mul/div latency down-counter.
    localparam int MD_CNT_W = 8;

endpackage : cpu_pkg

// File: rtl/fwd_port_match.sv
// Per-read-port forwarding match: picks the youngest in-flight writer of the
// port's register and flags a hazard if that writer's result is not ready yet.
module fwd_port_match
    import cpu_pkg::*;
#(
    parameter int NST  = 2,
    parameter int SELW = 2
) (
    input  logic [4:0]      addr,
    input  logic            used,
    input  logic [NST-1:0]  st_wreg,
    input  logic [NST*5-1:0] st_dst,
    input  logic [NST-1:0]  st_rdy,
    output logic [SELW-1:0] sel,
    output logic            hazard
);

    logic sel_rdy;

    // Scan oldest to youngest so the stage nearest EXE overrides older matches.
    always_comb begin
        sel     = SELW'(FW_SEL_RF);
        sel_rdy = 1'b1;
        for (int s = NST - 1; s >= 0; s--) begin
            if (st_wreg[s] && (st_dst[s*5 +: 5] == addr)) begin
                sel     = SELW'(s + 1);
                sel_rdy = st_rdy[s];
            end
        end
        if (addr == REG_ZERO) begin
            sel     = SELW'(FW_SEL_RF);
            sel_rdy = 1'b1;
        end
        // A not-ready youngest writer stalls; an older ready copy is stale.
        hazard = used && !sel_rdy;
    end

endmodule : fwd_port_match

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and stall control for the EXE/ID read ports, plus the
// multicycle mul/div busy tracker guarding HI/LO reads.
// Optional build macro FWD_STALL_CNT_EN adds a saturating stall-cycle counter
// output (stall_cnt); without it the port and register do not exist.
module fwd_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter  int NST    = 2,
    parameter  int NRP    = 4,
    parameter  int MD_LAT = 32,
    localparam int SELW   = $clog2(NST + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NRP*5-1:0]   rd_addr,
    input  logic [NRP-1:0]     rd_used,
    input  logic [NST-1:0]     st_wreg,
    input  logic [NST*5-1:0]   st_dst,
    input  logic [NST-1:0]     st_rdy,
    input  logic               hilo_rd,
    input  logic               md_start,
    input  logic               md_cancel,
    output logic [NRP*SELW-1:0] fw_sel,
`ifdef FWD_STALL_CNT_EN
    output logic               stall,
    output logic               md_busy,
    output logic [31:0]        stall_cnt
`else
    output logic               stall,
    output logic               md_busy
`endif
);

    logic [NRP*SELW-1:0] sel_raw;
    logic [NRP-1:0]      hazard;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    for (genvar p = 0; p < NRP; p++) begin : g_port
        fwd_port_match #(
            .NST  (NST),
            .SELW (SELW)
        ) u_match (
            .addr    (rd_addr[p*5 +: 5]),
            .used    (rd_used[p]),
            .st_wreg (st_wreg),
            .st_dst  (st_dst),
            .st_rdy  (st_rdy),
            .sel     (sel_raw[p*SELW +: SELW]),
            .hazard  (hazard[p])
        );
    end

    // Outputs are forced quiet while reset is held, even mid mul/div.
    always_comb begin
        md_busy = rst_n && (md_cnt_q != '0);
        fw_sel  = rst_n ? sel_raw : '0;
        stall   = rst_n && ((|hazard) || (hilo_rd && md_busy));
    end

    // Mul/div countdown: cancel beats start, start reloads even when busy.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cancel) begin
            md_cnt_d = '0;
        end else if (md_start) begin
            md_cnt_d = MD_CNT_W'(MD_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // Mul/div counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) md_cnt_q <= '0;
        else        md_cnt_q <= md_cnt_d;
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count stalled cycles, sticking at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : fwd_hazard_ctrl
